// File: rtl/sll32_seq.sv
// sll32_seq: multi-cycle logical left shifter with start/busy/done handshake
module sll32_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             var_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done,
  output logic             ready
);
  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
      $error("sll32_seq: STEP must be 1, 2, 4 or 8");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [4:0] STEP5 = 5'(STEP);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       amt;
  logic [4:0]       k;
  logic             accept;
  logic             unused_b;
  assign unused_b = ^{B[WIDTH-1:11], B[5]};
  // shift amount selection, per-cycle step size and start acceptance
  always_comb begin
    amt    = var_mode ? B[4:0] : B[10:6];
    k      = (cnt_q < STEP5) ? cnt_q : STEP5;
    accept = start && (state_q != SHIFT);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next-state logic; DONE accepts a new start just like IDLE
  always_comb begin
    state_d = (state_q == SHIFT) ? ((cnt_q == k) ? DONE : SHIFT)
            : start              ? ((amt == 5'd0) ? DONE : SHIFT)
            :                      IDLE;
  end
  // datapath next-state: load on accept, shift by k while in SHIFT, else hold
  always_comb begin
    res_d = accept ? A : (state_q == SHIFT) ? res_q << k : res_q;
    cnt_d = accept ? amt : (state_q == SHIFT) ? cnt_q - k : cnt_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end
  // handshake outputs decoded from registered state only
  always_comb begin
    busy  = (state_q == SHIFT);
    ready = (state_q != SHIFT);
    done  = (state_q == DONE);
    res   = res_q;
  end
endmodule

// File: doc/sll32_seq.md
Name: sll32_seq

Overview:
- Multi-cycle logical left shifter; the left-shift counterpart of the ALU's combinational logical right shifter.
- Serves the multi-cycle datapath for SLL and SLLV. It takes A as the operand and gets the shift amount from B.
- Shift amount source:
  - B[10:6] (shamt field) for SLL.
  - B[4:0] for SLLV.
- Uses a start/busy/done handshake so the control unit can stall until the result is ready.

Parameters:
- WIDTH, 32: operand and result width. Shift amount is always 5 bits.
- STEP, 1: bits shifted per SHIFT cycle. Legal values are 1, 2, 4, 8. Any other value is a synthesis error.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request. Sampled only in IDLE or DONE.
- var_mode  input  1  0: amount = B[10:6]; 1: amount = B[4:0]. Sampled with start.
- A  input  WIDTH  operand to shift. Sampled with start.
- B  input  WIDTH  instruction/register word supplying the amount. Sampled with start.
- res  output  WIDTH  result register.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; res is valid.
- ready  output  1  high in IDLE or DONE (start will be accepted).

Behaviour:
- Interface:
  - One clock. Reset is synchronous and active-high; rst is sampled on the rising edge of clk.
  - While rst=1: state=IDLE, res=0, cnt=0, busy=0, done=0, ready=1.
- State machine (3 states: IDLE, SHIFT, DONE):
  - IDLE:
    - start=1: capture res<=A and cnt<=amount.
    - Go to DONE if amount==0, else to SHIFT.
    - start=0: stay in IDLE, res holds.
  - SHIFT:
    - Each cycle: k = min(STEP, cnt); res <= res << k (zero fill from bit 0); cnt <= cnt - k.
    - When cnt-k == 0, go to DONE.
    - start is ignored; A, B and var_mode may change freely.
  - DONE:
    - done=1 for exactly this cycle; res holds the final value.
    - start=1: accepted exactly as in IDLE (back-to-back, no bubble).
    - start=0: go to IDLE.
- Latency:
  - done is asserted ceil(amount/STEP)+1 cycles after the edge that samples start.
  - amount=0 gives 1 cycle. amount=31 with STEP=1 gives 32 cycles.
  - amount=31 with STEP=4 gives 9 cycles; the last step uses k=3.
- Output qualification:
  - busy = (state==SHIFT). ready = (state!=SHIFT). done = (state==DONE).
  - All are registered-state decodes; none is a combinational function of start.
- Result arithmetic: final res == (A << amount) truncated to WIDTH; bits shifted out are lost. No sign handling, no carry/overflow output.
- res update rules:
  - res changes only on an accept edge or in SHIFT.
  - res holds from DONE through IDLE until the next accepted start.
  - Intermediate values are visible in SHIFT; consumers must qualify res with done.
- Boundary cases:
  - B bits outside the selected 5-bit field are ignored.
  - var_mode=0 ignores B[4:0]; var_mode=1 ignores B[10:6].
- Reset mid-operation: rst=1 in SHIFT or DONE aborts. The next cycle is IDLE with res=0 and no done pulse. A start coincident with rst is dropped.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with start=1 → res=0, busy=0, done=0, ready=1. No done pulse after rst falls until a new start.
- SLL basic: var_mode=0, A=32'h0000_0001, B=32'h0000_07C0 (shamt=31), STEP=1 → busy for 31 cycles. done on cycle 32 after the start edge, res=32'h8000_0000.
- SLLV + truncation: var_mode=1, A=32'hF000_000F, B=32'hFFFF_FFE4 (amount=4) → done 5 cycles after start, res=32'h0000_00F0. Upper B bits are ignored.
- Zero amount and back-to-back:
  - start A=32'h1234_5678, amount=0 → done 1 cycle later, res=32'h1234_5678.
  - start held in that DONE cycle with amount=8 → next done 9 cycles later, res=32'h3456_7800.
- Abort and ignore:
  - Mid-SHIFT, pulse start with different A → ignored, result unchanged.
  - Separate run: assert rst at SHIFT cycle 3 → IDLE next cycle, res=0, no done.
- STEP=4 rerun of the SLL basic case → done 9 cycles after start, res=32'h8000_0000. Random A/amount sweep of 1000 ops compared against A<<amount.
